// File: rtl/registro_desp_nb_pkg.sv
// rtl/registro_desp_nb_pkg.sv - shared state encoding and width helper
// Purpose: state constants for the shift FSM and a constant-foldable
//          ceil(log2) used to size the bit counter (CW = CLOG2(WIDTH+1)).
package registro_desp_nb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  // Smallest r with 2**r >= value; the loop bound covers every legal WIDTH.
  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/registro_desp_nb_if.sv
// rtl/registro_desp_nb_if.sv - load/shift/status bundle for the serialiser
// Purpose: groups the load handshake, shift/abort controls and status outputs.
// master: drives din, load_valid, shift_en, abort; observes the rest.
// slave : the shift register itself.
interface registro_desp_nb_if #(
  parameter int WIDTH = 8
) ();
  import registro_desp_nb_pkg::*;

  localparam int CW = CLOG2(WIDTH + 1);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             abort;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic [CW-1:0]    count;
  logic             done;

  modport master (
    output din, load_valid, shift_en, abort,
    input  load_ready, dout, sout, busy, count, done
  );

  modport slave (
    input  din, load_valid, shift_en, abort,
    output load_ready, dout, sout, busy, count, done
  );

endinterface

// File: rtl/contador_desc_nb.sv
// rtl/contador_desc_nb.sv - saturating down-counter with sync load
// Purpose: holds the bits-remaining count of the serialiser.
// Ports: CLK, RST_N (sync, active low); clr, load, dec controls
//        (priority clr > load > dec); load_val; count; zero (count==0);
//        last (count==1, i.e. the next decrement finishes the word).
module contador_desc_nb #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          last
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      // Saturate at zero so the count can never wrap.
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
  assign last  = (cnt_q == CW'(1));

endmodule

// File: rtl/registro_desp_nb.sv
// rtl/registro_desp_nb.sv - parallel-load / serial-shift register with handshake
// Purpose: accepts a WIDTH-bit symbol pattern and emits it one bit per
//          shift_en strobe, with a one-cycle done pulse after the last bit.
// Ports: CLK, RST_N (sync, active low); bus (slave modport) carrying
//        din/load_valid/load_ready, shift_en, abort, dout, sout, busy,
//        count and done.
module registro_desp_nb
  import registro_desp_nb_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0
) (
  input logic               CLK,
  input logic               RST_N,
  registro_desp_nb_if.slave bus
);

  localparam int CW = CLOG2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] shifted;
  logic             done_q;
  logic             load_go;
  logic             shift_go;
  logic             cnt_zero;
  logic             cnt_last;

  // Abort outranks load and shift, so it gates both strobes to the counter.
  assign load_go  = (state == IDLE)  && bus.load_valid && !bus.abort;
  assign shift_go = (state == SHIFT) && bus.shift_en && !bus.abort && !cnt_zero;

  always_comb begin
    shifted = dout_q;
    if (MSB_FIRST) shifted = {dout_q[WIDTH-2:0], FILL};
    else           shifted = {FILL, dout_q[WIDTH-1:1]};
  end

  contador_desc_nb #(
    .CW (CW)
  ) u_contador (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (bus.abort),
    .load     (load_go),
    .dec      (shift_go),
    .load_val (CW'(WIDTH)),
    .count    (bus.count),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      dout_q <= '0;
      done_q <= 1'b0;
    end else if (bus.abort) begin
      state  <= IDLE;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            dout_q <= bus.din;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_go) begin
            dout_q <= shifted;
            // The shift consuming the final bit closes the word.
            if (cnt_last) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state == SHIFT);
  assign bus.load_ready = (state == IDLE);
  assign bus.sout       = (state == SHIFT) ? (MSB_FIRST ? dout_q[WIDTH-1] : dout_q[0]) : FILL;

endmodule

// File: tb/tb_registro_desp_nb.sv
// tb/tb_registro_desp_nb.sv - scoreboard bench for registro_desp_nb
module tb_registro_desp_nb;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  // a: MSB first, FILL 0.  b: LSB first, FILL 1.  Both see identical stimulus.
  registro_desp_nb_if #(.WIDTH(W)) bus_a ();
  registro_desp_nb_if #(.WIDTH(W)) bus_b ();

  registro_desp_nb #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL(1'b0)) dut_a (
    .CLK (CLK), .RST_N (RST_N), .bus (bus_a)
  );
  registro_desp_nb #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL(1'b1)) dut_b (
    .CLK (CLK), .RST_N (RST_N), .bus (bus_b)
  );

  typedef struct {
    logic         busy;
    logic         done;
    logic [3:0]   cnt;
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         sa;
    logic         sb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: a word in flight plus how many of its bits have left.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_k    = 0;
  int           m_left = 0;
  logic [W-1:0] m_da   = '0;
  logic [W-1:0] m_db   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic rst_n, input logic ab, input logic lv,
                              input logic [W-1:0] d, input logic se);
    m_done = 1'b0;
    if (!rst_n || ab) begin
      m_busy = 1'b0; m_left = 0; m_da = '0; m_db = '0;
    end else if (!m_busy) begin
      if (lv) begin
        m_busy = 1'b1; m_word = d; m_k = 0; m_left = W;
        m_da = d; m_db = d;
      end
    end else if (se) begin
      m_k++;
      m_left--;
      // After k bits leave, k fill bits occupy the vacated end.
      m_da = m_word << m_k;
      m_db = (m_word >> m_k) | ~({W{1'b1}} >> m_k);
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic ab, input logic lv,
                      input logic [W-1:0] d, input logic se);
    exp_t e;
    @(negedge CLK);
    RST_N = rst_n;
    bus_a.abort = ab; bus_a.load_valid = lv; bus_a.din = d; bus_a.shift_en = se;
    bus_b.abort = ab; bus_b.load_valid = lv; bus_b.din = d; bus_b.shift_en = se;
    model_update(rst_n, ab, lv, d, se);
    e.busy = m_busy;
    e.done = m_done;
    e.cnt  = 4'(m_left);
    e.da   = m_da;
    e.db   = m_db;
    e.sa   = m_busy ? m_word[W-1-m_k] : 1'b0;
    e.sb   = m_busy ? m_word[m_k]     : 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every issued cycle has one expected snapshot, checked after the edge.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("busy_a",  32'(bus_a.busy),       32'(mon_e.busy));
      chk("ready_a", 32'(bus_a.load_ready), 32'(!mon_e.busy));
      chk("done_a",  32'(bus_a.done),       32'(mon_e.done));
      chk("count_a", 32'(bus_a.count),      32'(mon_e.cnt));
      chk("dout_a",  32'(bus_a.dout),       32'(mon_e.da));
      chk("sout_a",  32'(bus_a.sout),       32'(mon_e.sa));
      chk("busy_b",  32'(bus_b.busy),       32'(mon_e.busy));
      chk("ready_b", 32'(bus_b.load_ready), 32'(!mon_e.busy));
      chk("done_b",  32'(bus_b.done),       32'(mon_e.done));
      chk("count_b", 32'(bus_b.count),      32'(mon_e.cnt));
      chk("dout_b",  32'(bus_b.dout),       32'(mon_e.db));
      chk("sout_b",  32'(bus_b.sout),       32'(mon_e.sb));
    end
  end

  int r;

  initial begin
    bus_a.abort = 1'b0; bus_a.load_valid = 1'b0; bus_a.din = '0; bus_a.shift_en = 1'b0;
    bus_b.abort = 1'b0; bus_b.load_valid = 1'b0; bus_b.din = '0; bus_b.shift_en = 1'b0;

    // Reset, then A5 with gaps between strobes.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // shift_en while idle must not disturb anything.
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // 0F with load_valid held high and din churning during the word.
    step(1'b1, 1'b0, 1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Abort after three strobes, colliding with shift and load.
    step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Back-to-back: reload on the done cycle, then reset mid-word.
    step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    repeat (W) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      step((r < 2) ? 1'b0 : 1'b1, (r >= 2 && r < 5), ($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom_range(0, 1)));
    end

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
